s27_bist: RTL and testbench

Self-test driver and response compactor for the s27 benchmark core. It generates pseudo-random stimulus for inputs G0..G3 and compacts the single output G17 into a 16-bit signature. It runs a start/done sequence on its controller side: it initialises the core, applies N_PAT patterns, then reports the signature and a pass/fail compare. It sits beside the core, sharing its clock; the core's CK, G0..G3 and G17 connect to this block.

---
 rtl/s27_bist.sv | 166 ++++++++++++++++
 tb/tb_s27_bist.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/s27_bist.sv
// s27_bist -- self-test driver and response compactor for the s27 core.
//
// Drives pseudo-random stimulus onto the core inputs G0..G3 from an 8-bit
// Fibonacci LFSR and folds the core output G17 into a 16-bit serial MISR
// (CRC-16-CCITT). A start/done controller first holds INIT_VEC for INIT_CYC
// cycles to flush the core's unreset flops, then compacts N_PAT patterns
// and finally reports the signature together with a golden compare.
//
// Parameters
//   N_PAT    number of compacted patterns, 1..65535
//   INIT_CYC flush cycles before compaction, 0..255
//   INIT_VEC stimulus held in IDLE, INIT and DONE
//   SEED     LFSR load value, must be non-zero
//   GOLDEN   expected signature
//
// Ports
//   CK     in   clock, all state on the rising edge (shared with the core)
//   RST    in   synchronous active-high reset
//   START  in   begin a test; honoured in IDLE and DONE only
//   BUSY   out  high in INIT and RUN
//   DONE   out  high in DONE
//   PASS   out  in DONE: signature equals GOLDEN; 0 elsewhere
//   TI     out  stimulus, TI[0..3] drive G0..G3
//   RSP    in   core response (G17)
//   SIG    out  current MISR contents
module s27_bist #(
  parameter int unsigned N_PAT    = 255,
  parameter int unsigned INIT_CYC = 4,
  parameter logic [3:0]  INIT_VEC = 4'b0000,
  parameter logic [7:0]  SEED     = 8'h01,
  parameter logic [15:0] GOLDEN   = 16'h0000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [3:0]  TI,
  input  logic        RSP,
  output logic [15:0] SIG
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Terminal counts; INIT_LAST is only consulted when INIT_CYC is non-zero.
  localparam logic [15:0] N_LAST    = 16'(N_PAT - 1);
  localparam logic [15:0] INIT_LAST = 16'(INIT_CYC - 1);
  localparam logic        HAS_INIT  = (INIT_CYC != 0);

  // One step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    logic fb;
    fb = l[7] ^ l[5] ^ l[4] ^ l[3];
    return {l[6:0], fb};
  endfunction

  // One serial CRC-16-CCITT step folding a single response bit into the MISR.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic r);
    logic f;
    f = s[15] ^ r;
    return {s[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
  endfunction

  state_t      state_r;
  logic [7:0]  lfsr_r;
  logic [15:0] sig_r;
  logic [15:0] cnt_r;
  logic        busy_r;
  logic        done_r;
  logic        pass_r;
  logic [15:0] sig_nxt_s;
  logic [3:0]  ti_s;

  // Signature the MISR would hold after folding the response of this cycle.
  always_comb begin
    sig_nxt_s = misr_step(sig_r, RSP);
  end

  // Stimulus mux: the core only sees LFSR patterns while compacting.
  always_comb begin
    ti_s = INIT_VEC;
    if (state_r == ST_RUN) begin
      ti_s = lfsr_r[3:0];
    end else begin
      ti_s = INIT_VEC;
    end
  end

  // Controller, pattern generator, MISR and registered status flags.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      lfsr_r  <= SEED;
      sig_r   <= 16'h0000;
      cnt_r   <= 16'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      case (state_r)
        // IDLE and DONE both wait for START; DONE keeps the last result.
        ST_IDLE, ST_DONE: begin
          if (START) begin
            lfsr_r  <= SEED;
            sig_r   <= 16'h0000;
            cnt_r   <= 16'd0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            state_r <= HAS_INIT ? ST_INIT : ST_RUN;
          end else begin
            state_r <= state_r;
          end
        end

        // Flush the core with INIT_VEC; signature and LFSR stay put.
        ST_INIT: begin
          if (cnt_r == INIT_LAST) begin
            cnt_r   <= 16'd0;
            state_r <= ST_RUN;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
          end
        end

        // Compact one pattern per cycle; the response belongs to the
        // pattern driven in this same cycle.
        ST_RUN: begin
          sig_r  <= sig_nxt_s;
          lfsr_r <= lfsr_step(lfsr_r);
          cnt_r  <= cnt_r + 16'd1;
          if (cnt_r == N_LAST) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            // Compare against the signature being written, so PASS and
            // DONE rise on the same edge.
            pass_r  <= (sig_nxt_s == GOLDEN);
          end else begin
            state_r <= ST_RUN;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = busy_r;
  assign DONE = done_r;
  assign PASS = pass_r;
  assign SIG  = sig_r;
  assign TI   = ti_s;

endmodule

// File: tb/tb_s27_bist.sv
// Bench for s27_bist. Two instances: A (INIT_CYC=0, N_PAT=255) whose RSP
// comes from a small combinational stand-in for the core, and B (INIT_CYC=4,
// N_PAT=2, GOLDEN=16'h3063) whose RSP is driven directly. A time-based model
// (cycles elapsed since the accepted START) predicts every output each cycle.
module tb_s27_bist;

  logic             clk = 1'b0;
  logic [1:0]       rst_i = 2'b11;
  logic [1:0]       start_i = 2'b00;
  logic             rsp_a;
  logic             rsp_b = 1'b0;
  logic [1:0]       busy_o, done_o, pass_o;
  logic [1:0][3:0]  ti_o;
  logic [1:0][15:0] sig_o;

  int errors = 0;
  int checks = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  s27_bist #(.N_PAT(255), .INIT_CYC(0), .INIT_VEC(4'b0000), .SEED(8'h01),
             .GOLDEN(16'h0000)) dut_a (
    .CK(clk), .RST(rst_i[0]), .START(start_i[0]), .BUSY(busy_o[0]),
    .DONE(done_o[0]), .PASS(pass_o[0]), .TI(ti_o[0]), .RSP(rsp_a),
    .SIG(sig_o[0]));

  s27_bist #(.N_PAT(2), .INIT_CYC(4), .INIT_VEC(4'b0000), .SEED(8'h01),
             .GOLDEN(16'h3063)) dut_b (
    .CK(clk), .RST(rst_i[1]), .START(start_i[1]), .BUSY(busy_o[1]),
    .DONE(done_o[1]), .PASS(pass_o[1]), .TI(ti_o[1]), .RSP(rsp_b),
    .SIG(sig_o[1]));

  // Stand-in core: G17 as a fixed combinational function of G0..G3.
  function automatic logic core_fn(input logic [3:0] t);
    return (t[0] & t[1]) ^ t[2] ^ t[3];
  endfunction
  assign rsp_a = core_fn(ti_o[0]);

  function automatic logic [7:0] lf_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  function automatic logic [15:0] crc_bit(input logic [15:0] s, input logic r);
    return (s << 1) ^ (((s >> 15) & 16'h0001) != {15'd0, r} ? 16'h1021 : 16'h0000);
  endfunction

  // ---------------- model ----------------
  int          icyc [2] = '{0, 4};
  int          npat [2] = '{255, 2};
  logic [15:0] gold [2] = '{16'h0000, 16'h3063};
  logic [3:0]  pat [255];
  int          cyc = 0;
  bit          act [2] = '{1'b0, 1'b0};
  int          ts [2] = '{0, 0};
  logic [15:0] sig_m [2] = '{16'h0000, 16'h0000};
  logic [15:0] exp_full;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model update on each edge, from the inputs seen at that edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int e;
      e = cyc - ts[i];
      if (rst_i[i]) begin
        act[i]   <= 1'b0;
        sig_m[i] <= 16'h0000;
      end else if (!act[i] || e >= icyc[i] + npat[i]) begin
        if (start_i[i]) begin
          act[i]   <= 1'b1;
          ts[i]    <= cyc + 1;
          sig_m[i] <= 16'h0000;
        end
      end else if (e >= icyc[i]) begin
        sig_m[i] <= crc_bit(sig_m[i], (i == 0) ? rsp_a : rsp_b);
      end
    end
    cyc <= cyc + 1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        logic eb, ed, ep;
        logic [3:0] et;
        int e;
        eb = 1'b0; ed = 1'b0; ep = 1'b0; et = 4'b0000;
        if (act[i]) begin
          e = cyc - ts[i];
          if (e < icyc[i] + npat[i]) begin
            eb = 1'b1;
            if (e >= icyc[i]) et = pat[(e - icyc[i]) % 255];
          end else begin
            ed = 1'b1;
            ep = (sig_m[i] == gold[i]);
          end
        end
        chk($sformatf("busy[%0d]", i), {31'd0, busy_o[i]}, {31'd0, eb});
        chk($sformatf("done[%0d]", i), {31'd0, done_o[i]}, {31'd0, ed});
        chk($sformatf("pass[%0d]", i), {31'd0, pass_o[i]}, {31'd0, ep});
        chk($sformatf("ti[%0d]", i), {28'd0, ti_o[i]}, {28'd0, et});
        chk($sformatf("sig[%0d]", i), {16'd0, sig_o[i]}, {16'd0, sig_m[i]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int i, input int maxc);
    int n;
    n = 0;
    while (done_o[i] !== 1'b1 && n < maxc) begin
      tick(1);
      n++;
    end
    chk($sformatf("done_reached[%0d]", i), {31'd0, done_o[i]}, 32'd1);
  endtask

  initial begin
    logic [7:0]  l;
    logic [15:0] s;
    logic [15:0] sig_full;
    logic [3:0]  ti_lit [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h3};

    l = 8'h01;
    s = 16'h0000;
    for (int k = 0; k < 255; k++) begin
      pat[k] = l[3:0];
      s = crc_bit(s, core_fn(l[3:0]));
      l = lf_next(l);
    end
    exp_full = s;

    tick(1);
    armed = 1'b1;
    tick(1);
    rst_i = 2'b00;
    tick(10);
    for (int i = 0; i < 2; i++) begin
      chk("idle_busy", {31'd0, busy_o[i]}, 32'd0);
      chk("idle_done", {31'd0, done_o[i]}, 32'd0);
      chk("idle_pass", {31'd0, pass_o[i]}, 32'd0);
      chk("idle_sig", {16'd0, sig_o[i]}, 32'd0);
      chk("idle_ti", {28'd0, ti_o[i]}, 32'd0);
    end

    // A: stimulus sequence with INIT_CYC=0
    start_i[0] = 1'b1; tick(1); start_i[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("a_ti_run%0d", k), {28'd0, ti_o[0]}, {28'd0, ti_lit[k]});
      tick(1);
    end
    wait_done(0, 300);
    chk("a_full_sig", {16'd0, sig_o[0]}, {16'd0, exp_full});
    sig_full = sig_o[0];

    // B: RSP tied 1
    rsp_b = 1'b1;
    start_i[1] = 1'b1; tick(1); start_i[1] = 1'b0;
    chk("b_busy_init", {31'd0, busy_o[1]}, 32'd1);
    tick(5);
    chk("b_sig_run0", {16'd0, sig_o[1]}, 32'h1021);
    chk("b_done_early", {31'd0, done_o[1]}, 32'd0);
    tick(1);
    chk("b_done_t7", {31'd0, done_o[1]}, 32'd1);
    chk("b_sig_done", {16'd0, sig_o[1]}, 32'h3063);
    chk("b_pass1", {31'd0, pass_o[1]}, 32'd1);

    // B: RSP tied 0, restarted from DONE
    rsp_b = 1'b0;
    start_i[1] = 1'b1; tick(1); start_i[1] = 1'b0;
    chk("b_restart_sig", {16'd0, sig_o[1]}, 32'd0);
    chk("b_restart_busy", {31'd0, busy_o[1]}, 32'd1);
    tick(6);
    chk("b_done_rsp0", {31'd0, done_o[1]}, 32'd1);
    chk("b_sig_rsp0", {16'd0, sig_o[1]}, 32'd0);
    chk("b_pass0", {31'd0, pass_o[1]}, 32'd0);

    // B: START pulses during INIT and RUN are ignored
    rsp_b = 1'b1;
    start_i[1] = 1'b1; tick(1); start_i[1] = 1'b0;
    tick(2);
    start_i[1] = 1'b1; tick(1); start_i[1] = 1'b0;
    tick(2);
    start_i[1] = 1'b1; tick(1); start_i[1] = 1'b0;
    chk("b_ign_done", {31'd0, done_o[1]}, 32'd1);
    chk("b_ign_sig", {16'd0, sig_o[1]}, 32'h3063);
    tick(1);
    chk("b_done_hold", {31'd0, done_o[1]}, 32'd1);

    // B: START held high, back-to-back runs
    start_i[1] = 1'b1; tick(21); start_i[1] = 1'b0;
    tick(8);

    // A: reset in RUN cycle 100, then a coincident START/RST, then a clean run
    start_i[0] = 1'b1; tick(1); start_i[0] = 1'b0;
    tick(100);
    rst_i[0] = 1'b1; tick(1); rst_i[0] = 1'b0;
    chk("a_rst_busy", {31'd0, busy_o[0]}, 32'd0);
    chk("a_rst_sig", {16'd0, sig_o[0]}, 32'd0);
    chk("a_rst_ti", {28'd0, ti_o[0]}, 32'd0);
    rst_i[0] = 1'b1; start_i[0] = 1'b1; tick(1);
    rst_i[0] = 1'b0; start_i[0] = 1'b0;
    chk("a_rst_start_ignored", {31'd0, busy_o[0]}, 32'd0);
    start_i[0] = 1'b1; tick(1); start_i[0] = 1'b0;
    wait_done(0, 300);
    chk("a_rerun_sig", {16'd0, sig_o[0]}, {16'd0, sig_full});
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
